// File: rtl/pcie_gpio_target_if.sv
// RX/TX TLP streaming bundle between the PCIe core and the GPIO target.
// The core side (master) drives received words and the transmit ready;
// the target side (slave) drives the completion stream.
interface pcie_gpio_target_if;
  logic [15:0] rx_data;
  logic        rx_st;
  logic        rx_end;
  logic [6:0]  rx_bar_hit;
  logic        tx_req;
  logic        tx_rdy;
  logic        tx_st;
  logic        tx_end;
  logic [15:0] tx_data;

  modport master (
    output rx_data, rx_st, rx_end, rx_bar_hit, tx_rdy,
    input  tx_req, tx_st, tx_end, tx_data
  );

  modport slave (
    input  rx_data, rx_st, rx_end, rx_bar_hit, tx_rdy,
    output tx_req, tx_st, tx_end, tx_data
  );
endinterface

// File: rtl/pcie_gpio_target.sv
// PCIe BAR0 GPIO target: parses 16-bit MWr32/MRd32 TLP streams, serves a
// small register map (GPIO, scratch, ID) and returns one 8-word completion
// per accepted read, with posted/non-posted credit return pulses.
module pcie_gpio_target #(
  parameter logic [31:0] GPIO_RESET = 32'hFFFF_FFFE,
  parameter logic [31:0] ID_VALUE   = 32'h5449_0001
) (
  input  logic                    clk,
  input  logic                    rst,
  pcie_gpio_target_if.slave       bus,
  input  logic [7:0]              bus_num,
  input  logic [4:0]              dev_num,
  input  logic [2:0]              func_num,
  output logic [31:0]             gpio_out,
  output logic                    ph_processed,
  output logic                    pd_processed,
  output logic                    nph_processed,
  output logic                    drop_pulse
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SEND = 2'd2} tx_state_t;

  localparam logic [7:0] FT_MRD32 = 8'h00;
  localparam logic [7:0] FT_MWR32 = 8'h40;
  localparam logic [7:0] FT_MWR64 = 8'h60;

  // RX capture state
  logic [3:0]  cnt_r;        // index of the word on rx_data, saturates at 8
  logic        in_tlp_r;
  logic        bar_ok_r;
  logic [7:0]  fmt_type_r;
  logic        ep_r;
  logic [9:0]  len_r;
  logic [15:0] req_id_r;
  logic [7:0]  tag_r;
  logic [3:0]  first_be_r;
  logic [15:0] addr_lo_r;
  logic [15:0] data_hi_r;
  logic [31:0] scratch_r;

  // TX completion state, latched when a read is granted
  tx_state_t   state_r;
  logic [2:0]  widx_r;
  logic [15:0] cpl_req_id_r;
  logic [7:0]  cpl_tag_r;
  logic [4:0]  cpl_addr_r;
  logic [31:0] cpl_data_r;

  // Decode of the word currently on the bus (last word bypasses the regs)
  logic        active_s, end_s, bar_s, posted_s, idle_s;
  logic        is_mwr_s, is_mrd_s, ok_s, wr_s, rd_s, drop_s, cpl_done_s;
  logic [3:0]  idx_s;
  logic [7:0]  ft_s;
  logic [15:0] addr_lo_s;
  logic [31:0] wdata_s, rd_val_s;
  logic        unused_s;

  assign unused_s = ^{bus.rx_bar_hit[6:1], addr_lo_s[15:12], addr_lo_s[1:0]};

  // Byte-enable merge of a 32-bit write into an existing register value
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Completion word i built from the latched request fields
  function automatic logic [15:0] cpl_word(input logic [2:0] i);
    case (i)
      3'd0:    return 16'h4A00;
      3'd1:    return 16'h0001;
      3'd2:    return {bus_num, dev_num, func_num};
      3'd3:    return 16'h0004;
      3'd4:    return cpl_req_id_r;
      3'd5:    return {cpl_tag_r, 1'b0, cpl_addr_r, 2'b00};
      3'd6:    return cpl_data_r[31:16];
      3'd7:    return cpl_data_r[15:0];
      default: return 16'h0000;
    endcase
  endfunction

  // Classify the TLP ending this cycle and select the read-back value
  always_comb begin
    active_s   = bus.rx_st | in_tlp_r;
    idx_s      = bus.rx_st ? 4'd0 : cnt_r;
    end_s      = bus.rx_end & active_s;
    ft_s       = (idx_s == 4'd0) ? bus.rx_data[15:8] : fmt_type_r;
    bar_s      = bus.rx_st ? bus.rx_bar_hit[0] : bar_ok_r;
    addr_lo_s  = (idx_s == 4'd5) ? bus.rx_data : addr_lo_r;
    wdata_s    = {data_hi_r, bus.rx_data};
    idle_s     = (state_r == IDLE);
    posted_s   = (ft_s == FT_MWR32) | (ft_s == FT_MWR64);
    is_mwr_s   = (ft_s == FT_MWR32) & (idx_s == 4'd7);
    is_mrd_s   = (ft_s == FT_MRD32) & (idx_s == 4'd5);
    ok_s       = bar_s & ~ep_r & (len_r == 10'd1) & (is_mwr_s | is_mrd_s);
    wr_s       = end_s & ok_s & is_mwr_s;
    rd_s       = end_s & ok_s & is_mrd_s & idle_s;
    drop_s     = end_s & ~(ok_s & (is_mwr_s | (is_mrd_s & idle_s)));
    cpl_done_s = (state_r == SEND) & bus.tx_rdy & (widx_r == 3'd7);
    case (addr_lo_s[11:2])
      10'd0:   rd_val_s = gpio_out;
      10'd1:   rd_val_s = scratch_r;
      10'd2:   rd_val_s = ID_VALUE;
      default: rd_val_s = 32'h0000_0000;
    endcase
  end

  // Word counter and header/data field capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= 4'd0;
      in_tlp_r   <= 1'b0;
      bar_ok_r   <= 1'b0;
      fmt_type_r <= 8'h00;
      ep_r       <= 1'b0;
      len_r      <= 10'd0;
      req_id_r   <= 16'h0000;
      tag_r      <= 8'h00;
      first_be_r <= 4'h0;
      addr_lo_r  <= 16'h0000;
      data_hi_r  <= 16'h0000;
    end else begin
      if (active_s) begin
        in_tlp_r <= ~bus.rx_end;
        if (bus.rx_end)            cnt_r <= 4'd0;
        else if (bus.rx_st)        cnt_r <= 4'd1;
        else if (cnt_r != 4'd8)    cnt_r <= cnt_r + 4'd1;
        else                       cnt_r <= cnt_r;
        case (idx_s)
          4'd0: begin
            fmt_type_r <= bus.rx_data[15:8];
            bar_ok_r   <= bus.rx_bar_hit[0];
          end
          4'd1: begin
            ep_r  <= bus.rx_data[14];
            len_r <= bus.rx_data[9:0];
          end
          4'd2: req_id_r <= bus.rx_data;
          4'd3: begin
            tag_r      <= bus.rx_data[15:8];
            first_be_r <= bus.rx_data[3:0];
          end
          4'd5:    addr_lo_r <= bus.rx_data;
          4'd6:    data_hi_r <= bus.rx_data;
          default: ;
        endcase
      end else begin
        in_tlp_r <= 1'b0;
        cnt_r    <= 4'd0;
      end
    end
  end

  // Register file: byte-enabled writes to GPIO and scratch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out  <= GPIO_RESET;
      scratch_r <= 32'h0000_0000;
    end else if (wr_s) begin
      case (addr_lo_s[11:2])
        10'd0:   gpio_out  <= byte_merge(gpio_out, wdata_s, first_be_r);
        10'd1:   scratch_r <= byte_merge(scratch_r, wdata_s, first_be_r);
        default: ;
      endcase
    end
  end

  // Credit return and discard pulses, one cycle after the triggering event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_processed  <= 1'b0;
      pd_processed  <= 1'b0;
      nph_processed <= 1'b0;
      drop_pulse    <= 1'b0;
    end else begin
      ph_processed  <= end_s & posted_s;
      pd_processed  <= end_s & posted_s;
      nph_processed <= (drop_s & ~posted_s) | cpl_done_s;
      drop_pulse    <= drop_s;
    end
  end

  // Completion FSM: request the link, then stream 8 words under tx_rdy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      widx_r       <= 3'd0;
      bus.tx_req   <= 1'b0;
      bus.tx_st    <= 1'b0;
      bus.tx_end   <= 1'b0;
      bus.tx_data  <= 16'h0000;
      cpl_req_id_r <= 16'h0000;
      cpl_tag_r    <= 8'h00;
      cpl_addr_r   <= 5'd0;
      cpl_data_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (rd_s) begin
            state_r      <= REQ;
            bus.tx_req   <= 1'b1;
            cpl_req_id_r <= req_id_r;
            cpl_tag_r    <= tag_r;
            cpl_addr_r   <= addr_lo_s[6:2];
            cpl_data_r   <= rd_val_s;
          end
        end
        REQ: begin
          if (bus.tx_rdy) begin
            state_r     <= SEND;
            widx_r      <= 3'd0;
            bus.tx_req  <= 1'b0;
            bus.tx_st   <= 1'b1;
            bus.tx_end  <= 1'b0;
            bus.tx_data <= cpl_word(3'd0);
          end
        end
        SEND: begin
          if (bus.tx_rdy) begin
            if (widx_r == 3'd7) begin
              state_r     <= IDLE;
              widx_r      <= 3'd0;
              bus.tx_st   <= 1'b0;
              bus.tx_end  <= 1'b0;
              bus.tx_data <= 16'h0000;
            end else begin
              widx_r      <= widx_r + 3'd1;
              bus.tx_st   <= 1'b0;
              bus.tx_end  <= (widx_r == 3'd6);
              bus.tx_data <= cpl_word(widx_r + 3'd1);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          widx_r      <= 3'd0;
          bus.tx_req  <= 1'b0;
          bus.tx_st   <= 1'b0;
          bus.tx_end  <= 1'b0;
          bus.tx_data <= 16'h0000;
        end
      endcase
    end
  end

endmodule
